// File: rtl/icache_refill_if.sv
// Bundle of the miss/flush request, memory read channel and cache-write/critical-word outputs
// of the instruction-cache refill engine.
interface icache_refill_if #(
  parameter int ILEN       = 32,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_LEN   = 32
);
  localparam int LINE_LEN = ILEN * LINE_WORDS;

  logic                miss_i;
  logic [ADDR_LEN-1:0] miss_addr_i;
  logic                flush_i;
  logic                mem_req_valid_o;
  logic                mem_req_ready_i;
  logic [ADDR_LEN-1:0] mem_req_addr_o;
  logic                mem_resp_valid_i;
  logic [ILEN-1:0]     mem_resp_data_i;
  logic                mem_resp_err_i;
  logic                crit_valid_o;
  logic [ILEN-1:0]     crit_instr_o;
  logic                line_valid_o;
  logic [LINE_LEN-1:0] line_data_o;
  logic [ADDR_LEN-1:0] line_addr_o;
  logic                err_o;
  logic                busy_o;

  // Refill engine side
  modport master (
    input  miss_i, miss_addr_i, flush_i, mem_req_ready_i,
           mem_resp_valid_i, mem_resp_data_i, mem_resp_err_i,
    output mem_req_valid_o, mem_req_addr_o, crit_valid_o, crit_instr_o,
           line_valid_o, line_data_o, line_addr_o, err_o, busy_o
  );

  // Pipeline/memory side
  modport slave (
    output miss_i, miss_addr_i, flush_i, mem_req_ready_i,
           mem_resp_valid_i, mem_resp_data_i, mem_resp_err_i,
    input  mem_req_valid_o, mem_req_addr_o, crit_valid_o, crit_instr_o,
           line_valid_o, line_data_o, line_addr_o, err_o, busy_o
  );
endinterface

// File: rtl/icache_refill.sv
// Instruction-cache line refill: one line read per miss, critical word forwarded as it
// streams past, full line written to the cache unless the refill was flushed or errored.
module icache_refill #(
  parameter int ILEN       = 32,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_LEN   = 32
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  icache_refill_if.master bus
);
  localparam int OFFSET = $clog2(LINE_WORDS);
  localparam int WB     = $clog2(ILEN / 8);
  localparam int BOFF   = WB + OFFSET;

  typedef enum logic [1:0] {IDLE, REQ, FILL, WRITE} state_t;

  state_t              state_reg;
  logic [OFFSET-1:0]   cnt_reg;
  logic [OFFSET-1:0]   off_reg;
  logic                abort_reg;
  logic                err_reg;
  logic [ADDR_LEN-1:0] base_reg;
  logic                req_valid_reg;
  logic                line_valid_reg;
  logic                err_pulse_reg;
  logic                busy_reg;
  logic [ILEN-1:0]     word_reg [LINE_WORDS];

  logic beat_take;
  logic last_beat;
  logic abort_next;
  logic err_next;

  assign beat_take  = (state_reg == FILL) && bus.mem_resp_valid_i;
  assign last_beat  = &cnt_reg;
  assign abort_next = abort_reg | bus.flush_i;
  assign err_next   = err_reg | bus.mem_resp_err_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      off_reg        <= '0;
      abort_reg      <= 1'b0;
      err_reg        <= 1'b0;
      base_reg       <= '0;
      req_valid_reg  <= 1'b0;
      line_valid_reg <= 1'b0;
      err_pulse_reg  <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      line_valid_reg <= 1'b0;
      err_pulse_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.miss_i && !bus.flush_i) begin
            base_reg      <= {bus.miss_addr_i[ADDR_LEN-1:BOFF], {BOFF{1'b0}}};
            off_reg       <= bus.miss_addr_i[BOFF-1:WB];
            abort_reg     <= 1'b0;
            err_reg       <= 1'b0;
            req_valid_reg <= 1'b1;
            busy_reg      <= 1'b1;
            state_reg     <= REQ;
          end
        end
        REQ: begin
          // An accepted request must be drained even if flushed in the same cycle
          if (bus.mem_req_ready_i) begin
            req_valid_reg <= 1'b0;
            cnt_reg       <= '0;
            abort_reg     <= bus.flush_i;
            state_reg     <= FILL;
          end else if (bus.flush_i) begin
            req_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        FILL: begin
          if (bus.flush_i) abort_reg <= 1'b1;
          if (bus.mem_resp_valid_i) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (bus.mem_resp_err_i) err_reg <= 1'b1;
            if (last_beat) begin
              line_valid_reg <= !abort_next && !err_next;
              err_pulse_reg  <= !abort_next && err_next;
              state_reg      <= WRITE;
            end
          end
        end
        WRITE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < LINE_WORDS; i++) word_reg[i] <= '0;
    end else if (beat_take) begin
      for (int i = 0; i < LINE_WORDS; i++)
        if (cnt_reg == OFFSET'(i)) word_reg[i] <= bus.mem_resp_data_i;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_line
      assign bus.line_data_o[ILEN*gi +: ILEN] = word_reg[gi];
    end
  endgenerate

  assign bus.crit_valid_o    = beat_take && (cnt_reg == off_reg) && !abort_reg;
  assign bus.crit_instr_o    = bus.crit_valid_o ? bus.mem_resp_data_i : '0;
  assign bus.mem_req_valid_o = req_valid_reg;
  assign bus.mem_req_addr_o  = base_reg;
  assign bus.line_addr_o     = base_reg;
  assign bus.line_valid_o    = line_valid_reg;
  assign bus.err_o           = err_pulse_reg;
  assign bus.busy_o          = busy_reg;

  // Byte-within-word address bits carry no information for a line fetch
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.miss_addr_i[WB-1:0];
endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: expected critical words, lines and error pulses are queued
// as stimulus is driven and popped by a negedge monitor when the DUT emits them.
module tb_icache_refill;
  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;

  icache_refill_if #(.ILEN(32), .LINE_WORDS(4), .ADDR_LEN(32)) bus ();

  icache_refill #(.ILEN(32), .LINE_WORDS(4), .ADDR_LEN(32)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;
  int miss_cyc = 0;
  int line_cyc = -1;
  int err_cyc = -1;

  logic [31:0]  crit_q [$];
  logic [127:0] line_q [$];
  logic [31:0]  laddr_q [$];
  int           err_q [$];

  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every DUT output event must match the head of its queue
  always @(negedge clk_i) begin
    if (rst_n_i) begin
      if (bus.crit_valid_o) begin
        if (crit_q.size() == 0) chk("crit_unexpected", bus.crit_valid_o, 1'b0);
        else chk("crit_instr", bus.crit_instr_o, crit_q.pop_front());
      end
      if (bus.line_valid_o) begin
        line_cyc = cyc_cnt;
        if (line_q.size() == 0) chk("line_unexpected", bus.line_valid_o, 1'b0);
        else begin
          chk("line_data", bus.line_data_o, line_q.pop_front());
          chk("line_addr", bus.line_addr_o, laddr_q.pop_front());
        end
      end
      if (bus.err_o) begin
        err_cyc = cyc_cnt;
        if (err_q.size() == 0) chk("err_unexpected", bus.err_o, 1'b0);
        else void'(err_q.pop_front());
      end
    end
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue_miss(input logic [31:0] a);
    bus.miss_i      = 1'b1;
    bus.miss_addr_i = a;
    miss_cyc        = cyc_cnt;
    line_cyc        = -1;
    err_cyc         = -1;
    tick();
    bus.miss_i = 1'b0;
  endtask

  task automatic handshake(input int stall, input logic [31:0] exp_addr);
    bus.mem_req_ready_i = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk_i);
      chk("req_valid_stall", bus.mem_req_valid_o, 1'b1);
      chk("req_addr_stall", bus.mem_req_addr_o, exp_addr);
      tick();
    end
    bus.mem_req_ready_i = 1'b1;
    @(negedge clk_i);
    chk("req_valid", bus.mem_req_valid_o, 1'b1);
    chk("req_addr", bus.mem_req_addr_o, exp_addr);
    tick();
    bus.mem_req_ready_i = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic e, input bit exp_crit);
    if (exp_crit) crit_q.push_back(d);
    bus.mem_resp_valid_i = 1'b1;
    bus.mem_resp_data_i  = d;
    bus.mem_resp_err_i   = e;
    tick();
    bus.mem_resp_valid_i = 1'b0;
    bus.mem_resp_err_i   = 1'b0;
  endtask

  task automatic queues_empty(input string tag);
    chk({tag, "_crit_left"}, crit_q.size(), 0);
    chk({tag, "_line_left"}, line_q.size(), 0);
    chk({tag, "_err_left"}, err_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.miss_i = 1'b0; bus.miss_addr_i = '0; bus.flush_i = 1'b0;
    bus.mem_req_ready_i = 1'b0; bus.mem_resp_valid_i = 1'b0;
    bus.mem_resp_data_i = '0; bus.mem_resp_err_i = 1'b0;

    // Reset state
    @(negedge clk_i);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_req_valid", bus.mem_req_valid_o, 1'b0);
    chk("rst_line_data", bus.line_data_o, '0);
    chk("rst_line_addr", bus.line_addr_o, '0);
    chk("rst_line_valid", bus.line_valid_o, 1'b0);
    tick();
    rst_n_i = 1'b1;
    tick();

    // Basic refill, minimum latency, critical word is the 3rd beat
    line_q.push_back({32'hA3, 32'hA2, 32'hA1, 32'hA0});
    laddr_q.push_back(32'h1230);
    issue_miss(32'h0000_1238);
    chk("busy_req", bus.busy_o, 1'b1);
    handshake(0, 32'h1230);
    beat(32'hA0, 1'b0, 1'b0);
    beat(32'hA1, 1'b0, 1'b0);
    beat(32'hA2, 1'b0, 1'b1);
    beat(32'hA3, 1'b0, 1'b0);
    tick();
    chk("t1_line_latency", line_cyc, miss_cyc + 6);
    chk("t1_busy_after", bus.busy_o, 1'b0);
    queues_empty("t1");

    // Ready stalled three cycles
    line_q.push_back({32'hB3, 32'hB2, 32'hB1, 32'hB0});
    laddr_q.push_back(32'h1230);
    issue_miss(32'h0000_1238);
    handshake(3, 32'h1230);
    beat(32'hB0, 1'b0, 1'b0);
    beat(32'hB1, 1'b0, 1'b0);
    beat(32'hB2, 1'b0, 1'b1);
    beat(32'hB3, 1'b0, 1'b0);
    tick();
    chk("t2_line_latency", line_cyc, miss_cyc + 9);
    queues_empty("t2");

    // Flush during FILL after beat 1: no crit, no line, no error
    issue_miss(32'h0000_1238);
    handshake(0, 32'h1230);
    beat(32'hC0, 1'b0, 1'b0);
    beat(32'hC1, 1'b0, 1'b0);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    beat(32'hC2, 1'b0, 1'b0);
    beat(32'hC3, 1'b0, 1'b0);
    @(negedge clk_i);
    chk("t3_busy_write", bus.busy_o, 1'b1);
    chk("t3_line_valid", bus.line_valid_o, 1'b0);
    chk("t3_err", bus.err_o, 1'b0);
    tick();
    chk("t3_busy_after", bus.busy_o, 1'b0);
    queues_empty("t3");

    // Flush in REQ without handshake: back to IDLE, later beats ignored
    issue_miss(32'h0000_1238);
    bus.flush_i = 1'b1;
    @(negedge clk_i);
    chk("t4_req_valid", bus.mem_req_valid_o, 1'b1);
    tick();
    bus.flush_i = 1'b0;
    chk("t4_req_dropped", bus.mem_req_valid_o, 1'b0);
    chk("t4_busy", bus.busy_o, 1'b0);
    beat(32'hD0, 1'b0, 1'b0);
    beat(32'hD1, 1'b0, 1'b0);
    beat(32'hD2, 1'b0, 1'b0);
    beat(32'hD3, 1'b0, 1'b0);
    chk("t4_busy_after", bus.busy_o, 1'b0);
    queues_empty("t4");

    // Bus error on beat 0: err pulse in WRITE, no line write
    err_q.push_back(1);
    issue_miss(32'h0000_2004);
    handshake(0, 32'h2000);
    beat(32'hE0, 1'b1, 1'b0);
    beat(32'hE1, 1'b0, 1'b1);
    beat(32'hE2, 1'b0, 1'b0);
    beat(32'hE3, 1'b0, 1'b0);
    tick();
    chk("t5_err_latency", err_cyc, miss_cyc + 6);
    chk("t5_no_line", line_cyc, -1);
    queues_empty("t5");

    // Reset mid-FILL, then a clean refill after release
    issue_miss(32'h0000_300C);
    handshake(0, 32'h3000);
    beat(32'hF0, 1'b0, 1'b0);
    beat(32'hF1, 1'b0, 1'b0);
    rst_n_i = 1'b0;
    #1;
    chk("t6_rst_busy", bus.busy_o, 1'b0);
    chk("t6_rst_line_data", bus.line_data_o, '0);
    chk("t6_rst_line_addr", bus.line_addr_o, '0);
    chk("t6_rst_req_valid", bus.mem_req_valid_o, 1'b0);
    tick();
    rst_n_i = 1'b1;
    beat(32'hF2, 1'b0, 1'b0);
    beat(32'hF3, 1'b0, 1'b0);
    chk("t6_busy_idle", bus.busy_o, 1'b0);
    line_q.push_back({32'h93, 32'h92, 32'h91, 32'h90});
    laddr_q.push_back(32'h3000);
    issue_miss(32'h0000_300C);
    handshake(0, 32'h3000);
    beat(32'h90, 1'b0, 1'b0);
    beat(32'h91, 1'b0, 1'b0);
    beat(32'h92, 1'b0, 1'b0);
    beat(32'h93, 1'b0, 1'b1);
    tick();
    chk("t6_line_latency", line_cyc, miss_cyc + 6);
    queues_empty("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
